tensor_slice_driver: RTL and testbench
======================================

# tensor_slice_driver

Initiator-side controller for one `tensor_slice_int8` instance. It accepts matrix-multiply jobs (one A row, one B column, tag) on a valid/ready stream and issues each job to the slice as a one-cycle `start_mat_mul` pulse with stable operands. It captures the slice's one-cycle `c_data_available`/`c_data_out` result into a small FIFO and returns it tagged on a valid/ready result stream. It sits between the job scheduler and the slice, and flags slices that fail to respond.

## Interface
Parameters:
- `DEPTH`, 4: result FIFO entries (power of two, ≥2).
- `TIMEOUT`, 64: WAIT cycles before declaring the slice unresponsive (≤127).
- `TAG_W`, 8: job tag width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  job accepted when high with `job_valid` (registered).
- `job_a`  in  64  A row, 8×int8, lane i at [8i+:8].
- `job_b`  in  64  B column, 8×int8.
- `job_tag`  in  TAG_W  returned with result.
- `slice_start`  out  1  to slice `start_mat_mul`.
- `slice_a_data`  out  64  to slice `a_data`.
- `slice_b_data`  out  64  to slice `b_data`.
- `slice_c_available`  in  1  from slice `c_data_available`.
- `slice_c_data`  in  128  from slice `c_data_out`, 8×int16.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  128  result row.
- `res_tag`  out  TAG_W  tag of job.
- `res_err`  out  1  1 = timeout result, data is 0.
- `err_timeout`  out  1  sticky, set on any timeout.
- `clear_err`  in  1  synchronous clear of `err_timeout`.
- `op_count`  out  16  successful results captured, wraps 0xFFFF→0.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: `job_ready`=1 iff FIFO count < DEPTH. On handshake: latch `job_a`/`job_b`/`job_tag`, go ISSUE.
- ISSUE (exactly 1 cycle): `slice_start`=1; clear timer; go WAIT.
- WAIT: timer increments each cycle. On `slice_c_available`: push {tag, `slice_c_data`, err=0}, increment `op_count`, go IDLE. Else, when timer reaches TIMEOUT−1: push {tag, 128'd0, err=1}, set `err_timeout`, go IDLE.
- `slice_a_data`/`slice_b_data` hold the latched operands from ISSUE until the next acceptance; they are 0 after reset.
- At most one job is in flight. Because acceptance requires a free FIFO slot, the FIFO never overflows.
- `slice_c_available` outside WAIT is ignored (no push, no count).
- FIFO push and pop in the same cycle: both occur, count unchanged. Pop only when `res_valid && res_ready`.
- `res_*` reflect the FIFO head and stay stable while `res_valid && !res_ready`.
- `clear_err` and a new timeout in the same cycle: the flag stays set.

## Timing
- Reset values: `job_ready`, `slice_start`, `slice_a_data`, `slice_b_data`, `res_valid`, `res_data`, `res_tag`, `res_err`, `err_timeout`, `op_count`, `busy` are all 0. State is IDLE and the FIFO is empty.
- `job_ready` rises at the first edge after `reset_n` deasserts.
- Job accepted at edge E0 → `slice_start` high in cycle E0..E1.
- The slice registers its result 33 cycles after sampling start, so `slice_c_available` is high E34..E35.
- The push occurs at E35, so `res_valid` is high from E35.
- End-to-end latency is slice latency + 2 cycles.
- Back-to-back throughput is one job per 36 cycles.
- `job_ready` drops at the acceptance edge and rises at the edge that returns the FSM to IDLE with FIFO space.
- Timeout: no response through WAIT cycle TIMEOUT−1 → error entry pushed at the edge ending that cycle.
- Reset mid-operation abandons the in-flight job and flushes the FIFO; no result is emitted. The top level resets the slice together with the driver.

## Structure
- Shared package `tensor_slice_pkg` holds:
  - width constants `TS_A_W`=64 and `TS_C_W`=128;
  - the default `TAG_W`;
  - the FSM state enum (IDLE/ISSUE/WAIT);
  - the result entry struct {tag, err, data}.
- One sub-module, `tsd_result_fifo`: synchronous FIFO, DEPTH entries, registered head outputs, count output, asynchronous active-low reset.

## Test plan
- Single job, A=all 2, B=lanes 1..8, tag 0x5A, with the behavioural slice → `res_valid` 35 cycles after acceptance, `res_data` matches the slice output, `res_err`=0, `op_count`=1.
- Hold `res_ready`=0 and push DEPTH=4 jobs → `job_ready` stays 0 after the 4th result. Pop one → the next job is accepted. Results come out in order, tags 0..4.
- Slice never responds → `res_err`=1 with data 0 pushed exactly TIMEOUT cycles after `slice_start`, and `err_timeout` set. Then assert `clear_err` → `err_timeout` reads 0.
- Stray `slice_c_available` pulse while IDLE → no push, and `op_count` unchanged.
- Pulse `reset_n` low at cycle 10 of WAIT → all outputs 0, FIFO empty, and the next job completes normally with `op_count`=1.
- Preload `op_count` to 0xFFFF via 65535 jobs (or a force) → the next success wraps it to 0.

Source files
------------

// File: rtl/tensor_slice_pkg.sv
// tensor_slice_pkg: shared widths, driver FSM states and result entry layout
package tensor_slice_pkg;
    localparam int TS_A_W   = 64;
    localparam int TS_C_W   = 128;
    localparam int TS_TAG_W = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} ts_state_e;
    typedef struct packed {
        logic [TS_TAG_W-1:0] tag;
        logic                err;
        logic [TS_C_W-1:0]   data;
    } ts_res_t;
endpackage

// File: rtl/tsd_result_fifo.sv
// tsd_result_fifo: shift-register result FIFO whose head entry always lives in slot 0
module tsd_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 137
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic          w_pop, w_push;
    logic [CW-1:0] w_wr_idx;
    // a push into a full FIFO is only legal when a pop frees the head in the same cycle
    always_comb begin
        w_pop    = i_pop && (r_count != '0);
        w_push   = i_push && ((r_count != CW'(DEPTH)) || w_pop);
        w_wr_idx = r_count - CW'(w_pop);
    end
    // pop shifts every entry one slot toward the head; a push lands just above the last kept entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            for (int i = 0; i < DEPTH; i++)
                if (w_push && (w_wr_idx == CW'(i))) r_mem[i] <= i_data;
                else if (w_pop) r_mem[i] <= (i == DEPTH - 1) ? '0 : r_mem[(i + 1) % DEPTH];
        end
    end
    assign o_valid = r_count != '0;
    assign o_head  = r_mem[0];
    assign o_count = r_count;
endmodule

// File: rtl/tensor_slice_driver.sv
// tensor_slice_driver: issues queued matmul jobs to one int8 tensor slice and returns tagged results
module tensor_slice_driver
    import tensor_slice_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int TAG_W   = TS_TAG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [TS_A_W-1:0] job_a,
    input  logic [TS_A_W-1:0] job_b,
    input  logic [TAG_W-1:0]  job_tag,
    output logic              slice_start,
    output logic [TS_A_W-1:0] slice_a_data,
    output logic [TS_A_W-1:0] slice_b_data,
    input  logic              slice_c_available,
    input  logic [TS_C_W-1:0] slice_c_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [TS_C_W-1:0] res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_err,
    output logic              err_timeout,
    input  logic              clear_err,
    output logic [15:0]       op_count,
    output logic              busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = TAG_W + 1 + TS_C_W;
    ts_state_e         r_state, w_next;
    logic [6:0]        r_timer;
    logic [TAG_W-1:0]  r_tag;
    logic [TS_A_W-1:0] r_a, r_b;
    logic              r_job_ready, r_err;
    logic [15:0]       r_op_count;
    logic              w_accept, w_done, w_tmo, w_push, w_pop;
    logic [CW-1:0]     w_count, w_count_next;
    logic [EW-1:0]     w_entry, w_head;
    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    // next state: one ISSUE cycle per job, WAIT ends on a result or a timeout entry
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_push ? IDLE : WAIT;
            default: w_next = IDLE;
        endcase
    end
    // FSM outputs
    always_comb begin
        slice_start = r_state == ISSUE;
        busy        = r_state != IDLE;
    end
    // handshake and push decode; r_timer counts WAIT cycles from 0, so TIMEOUT-2 marks WAIT cycle TIMEOUT-1
    always_comb begin
        w_accept     = job_valid && r_job_ready;
        w_done       = (r_state == WAIT) && slice_c_available;
        w_tmo        = (r_state == WAIT) && !slice_c_available && (r_timer == 7'(TIMEOUT - 2));
        w_push       = w_done || w_tmo;
        w_pop        = res_valid && res_ready;
        w_entry      = {r_tag, w_tmo, w_tmo ? {TS_C_W{1'b0}} : slice_c_data};
        w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    end
    // operands stay on the slice bus from acceptance until the next acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_tag <= '0;
        end else if (w_accept) begin
            r_a   <= job_a;
            r_b   <= job_b;
            r_tag <= job_tag;
        end
    end
    // WAIT cycle timer, restarted by the ISSUE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_timer <= '0;
        else if (r_state == ISSUE) r_timer <= '0;
        else if (r_state == WAIT) r_timer <= r_timer + 7'd1;
    end
    // success counter and sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_count <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_done) r_op_count <= r_op_count + 16'd1;
            if (w_tmo) r_err <= 1'b1;
            else if (clear_err) r_err <= 1'b0;
        end
    end
    // job_ready is registered from the state and FIFO occupancy the next cycle will have
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_job_ready <= 1'b0;
        else r_job_ready <= (w_next == IDLE) && (w_count_next < CW'(DEPTH));
    end
    tsd_result_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .i_push (w_push),
        .i_data (w_entry),
        .i_pop  (w_pop),
        .o_valid(res_valid),
        .o_head (w_head),
        .o_count(w_count)
    );
    assign job_ready                   = r_job_ready;
    assign slice_a_data                = r_a;
    assign slice_b_data                = r_b;
    assign {res_tag, res_err, res_data} = w_head;
    assign err_timeout                 = r_err;
    assign op_count                    = r_op_count;
endmodule

// File: tb/tb_tensor_slice_driver.sv
// tb_tensor_slice_driver: directed and randomized jobs checked against a job-level scoreboard
module tb_tensor_slice_driver;
    import tensor_slice_pkg::*;
    localparam int TMO = 64;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         job_valid = 1'b0, job_ready;
    logic [63:0]  job_a = '0, job_b = '0;
    logic [7:0]   job_tag = '0;
    logic         slice_start, slice_c_available;
    logic [63:0]  slice_a_data, slice_b_data;
    logic [127:0] slice_c_data;
    logic         res_valid, res_ready = 1'b0, res_err, err_timeout, clear_err = 1'b0, busy;
    logic [127:0] res_data;
    logic [7:0]   res_tag;
    logic [15:0]  op_count;
    int           n_chk = 0, n_err = 0, pcyc = 0, rr_mode = 1;
    ts_res_t      q[$];
    logic [15:0]  exp_ops = '0;
    bit           slice_en = 1'b1, stray = 1'b0, hold = 1'b0;
    logic [159:0] held;
    int           s_cnt;
    logic         s_av;
    logic [63:0]  s_pa, s_pb;
    logic [127:0] s_data;

    tensor_slice_driver #(.DEPTH(4), .TIMEOUT(TMO), .TAG_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_a(job_a), .job_b(job_b), .job_tag(job_tag), .slice_start(slice_start),
        .slice_a_data(slice_a_data), .slice_b_data(slice_b_data),
        .slice_c_available(slice_c_available), .slice_c_data(slice_c_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
        .res_err(res_err), .err_timeout(err_timeout), .clear_err(clear_err),
        .op_count(op_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    function automatic logic [127:0] lane_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [7:0] x, y;
        logic [127:0] c = '0;
        for (int i = 0; i < 8; i++) begin
            x = a[8*i +: 8];
            y = b[8*i +: 8];
            c[16*i +: 16] = x * y;
        end
        return c;
    endfunction

    // behavioural slice: samples start, raises c_data_available 33 cycles later for one cycle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_cnt <= 0; s_av <= 1'b0; s_data <= '0; s_pa <= '0; s_pb <= '0;
        end else begin
            s_av <= 1'b0;
            if (slice_start && slice_en) begin
                s_cnt <= 33; s_pa <= slice_a_data; s_pb <= slice_b_data;
            end else if (s_cnt != 0) begin
                s_cnt <= s_cnt - 1;
                if (s_cnt == 1) begin s_av <= 1'b1; s_data <= lane_mul(s_pa, s_pb); end
            end
        end
    end
    assign slice_c_available = s_av | stray;
    assign slice_c_data = s_data;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // result consumer and scoreboard
    always @(negedge clk) begin
        ts_res_t e;
        if (rr_mode == 2) res_ready = 1'($urandom_range(0, 1));
        else if (rr_mode == 3) begin
            res_ready = res_valid;
            if (res_valid) rr_mode = 0;
        end else res_ready = (rr_mode == 1);
        if (hold && reset_n) check("hold_stable", {res_tag, res_err, res_data}, held);
        hold = res_valid && !res_ready;
        held = {res_tag, res_err, res_data};
        if (res_valid && res_ready) begin
            check("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("res_tag", res_tag, e.tag);
                check("res_err", res_err, e.err);
                check("res_data", res_data, e.data);
            end
        end
    end

    task automatic send(input logic [7:0] tag, input logic [63:0] a, input logic [63:0] b,
                        input bit en, output int acc);
        int n = 0;
        ts_res_t e;
        slice_en = en; job_a = a; job_b = b; job_tag = tag; job_valid = 1'b1;
        while (!job_ready && n < 1000) begin @(negedge clk); n++; end
        check("accept", n < 1000, 1);
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        acc = pcyc;
        e.tag = tag; e.err = !en; e.data = en ? lane_mul(a, b) : '0;
        q.push_back(e);
        if (en) exp_ops++;
    endtask

    task automatic wait_res(output int t);
        int n = 0;
        while (!res_valid && n < 300) begin @(negedge clk); n++; end
        check("res_wait", n < 300, 1);
        t = pcyc;
    endtask

    task automatic drain();
        int n = 0;
        rr_mode = 1;
        while ((busy || res_valid) && n < 500) begin @(negedge clk); n++; end
        check("drain", (n < 500) && (q.size() == 0), 1);
    endtask

    task automatic check_zero(input string p);
        check({p, "_job_ready"}, job_ready, 0);
        check({p, "_slice_start"}, slice_start, 0);
        check({p, "_slice_a"}, slice_a_data, 0);
        check({p, "_slice_b"}, slice_b_data, 0);
        check({p, "_res_valid"}, res_valid, 0);
        check({p, "_res_data"}, res_data, 0);
        check({p, "_res_tag"}, res_tag, 0);
        check({p, "_res_err"}, res_err, 0);
        check({p, "_err_timeout"}, err_timeout, 0);
        check({p, "_op_count"}, op_count, 0);
        check({p, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t;
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", job_ready, 1);
        // single job with known operands
        send(8'h5A, {8{8'h02}}, 64'h0807060504030201, 1'b1, acc);
        check("start_pulse", slice_start, 1);
        check("a_latched", slice_a_data, {8{8'h02}});
        check("busy_issue", busy, 1);
        @(negedge clk);
        check("start_drop", slice_start, 0);
        check("b_held", slice_b_data, 64'h0807060504030201);
        wait_res(t);
        check("latency", t - acc, 35);
        drain();
        check("ops_one", op_count, exp_ops);
        check("a_hold_idle", slice_a_data, {8{8'h02}});
        // fill the FIFO with the consumer stalled
        rr_mode = 0;
        for (int k = 0; k < 4; k++) send(8'(k), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, acc);
        t = 0;
        while (busy && t < 100) begin @(negedge clk); t++; end
        repeat (3) begin
            @(negedge clk);
            check("full_not_ready", job_ready, 0);
        end
        check("full_head_tag", res_tag, 0);
        rr_mode = 3;
        send(8'd4, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, acc);
        drain();
        // unresponsive slice
        send(8'h77, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, acc);
        wait_res(t);
        check("tmo_latency", t - acc, TMO);
        check("tmo_err_flag", err_timeout, 1);
        check("tmo_res_err", res_err, 1);
        check("tmo_res_data", res_data, 0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("err_cleared", err_timeout, 0);
        drain();
        // clear held high across a new timeout
        clear_err = 1'b1;
        send(8'h78, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, acc);
        wait_res(t);
        check("tmo_beats_clear", err_timeout, 1);
        clear_err = 1'b0;
        @(negedge clk);
        check("err_sticky", err_timeout, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("err_cleared2", err_timeout, 0);
        drain();
        // stray result pulse while idle
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_no_push", res_valid, 0);
        check("stray_ops", op_count, exp_ops);
        check("stray_idle", busy, 0);
        // reset in the middle of WAIT
        send(8'h33, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, acc);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero("midrst");
        q.delete();
        exp_ops = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(8'h34, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, acc);
        drain();
        check("ops_after_rst", op_count, 1);
        // randomized jobs with a random consumer
        rr_mode = 2;
        for (int k = 0; k < 16; k++) begin
            send(8'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 5) != 0, acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        check("rand_ops", op_count, exp_ops);
        // op_count wrap
        @(negedge clk);
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        exp_ops = 16'hFFFF;
        check("ops_preload", op_count, exp_ops);
        send(8'h99, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, acc);
        drain();
        check("ops_wrap", op_count, exp_ops);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
